// File: rtl/register_file.sv
// 32x32 general-purpose register file: two combinational read ports, one write port, entry 0 hardwired to zero.
// Latency: reads are zero-cycle; a write at edge N is visible just after edge N (no same-cycle bypass).
// Backpressure: none; every write is accepted on the edge it is presented.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  WriteRegister,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    input  logic [ADDR_WIDTH-1:0] WriteReg,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData1,
    output logic [DATA_WIDTH-1:0] ReadData2
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] regs_d [0:DEPTH-1];
    logic                  wr_en;

    assign wr_en = WriteRegister && (WriteReg != '0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[WriteReg] = WriteData;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Index 0 is masked on read so it reads zero even before the first reset.
    assign ReadData1 = (ReadRegister1 == '0) ? '0 : regs_q[ReadRegister1];
    assign ReadData2 = (ReadRegister2 == '0) ? '0 : regs_q[ReadRegister2];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed scenarios followed by randomized traffic against an array model.
module tb_register_file;

    logic        clock;
    logic        reset_n;
    logic        WriteRegister;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int vectors;
    int miscompares;
    logic [31:0] mdl [32];

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .WriteRegister (WriteRegister),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteReg      (WriteReg),
        .WriteData     (WriteData),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_read(input logic [4:0] idx);
        return (idx == 5'd0) ? 32'h0 : mdl[idx];
    endfunction

    task automatic mdl_clear();
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    endtask

    // Present a write on the next negedge, let the next posedge commit it.
    task automatic do_write(input logic we, input logic [4:0] addr, input logic [31:0] data);
        @(negedge clock);
        WriteRegister = we;
        WriteReg      = addr;
        WriteData     = data;
        @(posedge clock);
        #1;
        if (we && addr != 5'd0) mdl[addr] = data;
        WriteRegister = 1'b0;
    endtask

    task automatic read_pair(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                             input logic [31:0] e1, input logic [31:0] e2);
        ReadRegister1 = a1;
        ReadRegister2 = a2;
        #1;
        check({tag, "_rd1"}, ReadData1, e1);
        check({tag, "_rd2"}, ReadData2, e2);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset_n       = 1'b0;
        WriteRegister = 1'b0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        WriteReg      = 5'd0;
        WriteData     = 32'h0;
        mdl_clear();

        // Write attempted while in reset must not land.
        @(negedge clock);
        WriteRegister = 1'b1;
        WriteReg      = 5'd9;
        WriteData     = 32'hA5A5A5A5;
        @(posedge clock);
        #1;
        WriteRegister = 1'b0;
        read_pair("in_reset", 5'd9, 5'd31, 32'h0, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        read_pair("reset0", 5'd0, 5'd0, 32'h0, 32'h0);
        read_pair("reset7", 5'd7, 5'd7, 32'h0, 32'h0);
        read_pair("reset31", 5'd31, 5'd31, 32'h0, 32'h0);

        do_write(1'b1, 5'd7, 32'h0143C120);
        read_pair("wr7", 5'd7, 5'd0, 32'h0143C120, 32'h0);

        do_write(1'b1, 5'd21, 32'h0D43C127);
        read_pair("wr21", 5'd0, 5'd21, 32'h0, 32'h0D43C127);
        read_pair("keep7", 5'd7, 5'd7, 32'h0143C120, 32'h0143C120);

        do_write(1'b1, 5'd17, 32'h0943D120);
        read_pair("dual", 5'd21, 5'd17, 32'h0D43C127, 32'h0943D120);

        do_write(1'b0, 5'd17, 32'hFFFFFFFF);
        read_pair("we_low", 5'd17, 5'd17, 32'h0943D120, 32'h0943D120);

        do_write(1'b1, 5'd0, 32'hDEADBEEF);
        read_pair("zero_wr", 5'd0, 5'd0, 32'h0, 32'h0);

        // Asynchronous reset pulse between edges.
        @(negedge clock);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd17;
        #1;
        reset_n = 1'b0;
        mdl_clear();
        #1;
        check("arst_rd7", ReadData1, 32'h0);
        check("arst_rd17", ReadData2, 32'h0);
        ReadRegister1 = 5'd21;
        #1;
        check("arst_rd21", ReadData1, 32'h0);
        reset_n = 1'b1;

        // Same-cycle write and read: old value before edge, new one after.
        @(negedge clock);
        WriteRegister = 1'b1;
        WriteReg      = 5'd5;
        WriteData     = 32'h12345678;
        ReadRegister1 = 5'd5;
        #1;
        check("same_pre", ReadData1, 32'h0);
        @(posedge clock);
        #1;
        mdl[5] = 32'h12345678;
        WriteRegister = 1'b0;
        check("same_post", ReadData1, 32'h12345678);

        // Randomized traffic with occasional async reset pulses.
        for (int n = 0; n < 400; n++) begin
            logic        we;
            logic [4:0]  wa;
            logic [31:0] wd;
            logic [4:0]  r1;
            logic [4:0]  r2;
            we = ($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));

            @(negedge clock);
            WriteRegister = we;
            WriteReg      = wa;
            WriteData     = wd;
            ReadRegister1 = r1;
            ReadRegister2 = r2;
            #1;
            check("rnd_pre1", ReadData1, mdl_read(r1));
            check("rnd_pre2", ReadData2, mdl_read(r2));
            @(posedge clock);
            #1;
            if (we && wa != 5'd0) mdl[wa] = wd;
            check("rnd_post1", ReadData1, mdl_read(r1));
            check("rnd_post2", ReadData2, mdl_read(r2));
            WriteRegister = 1'b0;

            if ($urandom_range(0, 49) == 0) begin
                #1;
                reset_n = 1'b0;
                mdl_clear();
                #1;
                check("rnd_arst1", ReadData1, 32'h0);
                check("rnd_arst2", ReadData2, 32'h0);
                reset_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
